// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a 2^FIFO_ADDR_WIDTH-byte receive FIFO, popped with port A read timing.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag parity errors on perr.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       re,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       perr
);
    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned TICK_W    = $clog2(BIT_TICKS);
    localparam int unsigned DEPTH     = 1 << FIFO_ADDR_WIDTH;
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(BIT_TICKS / 2);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state, state_n;
    logic       sync1, rx, rx_prev;
    logic [1:0] primed;
    logic [TICK_W-1:0] tick;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       bit_end, shift_en, frame_ok, push_req;
`ifdef UART_RX_PARITY_EN
    logic       par_bit, par_sample, par_err, par_set;
`endif

    logic [7:0] mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wp, rp;
    logic [FIFO_ADDR_WIDTH:0]   count, count_n;
    logic pop, wr, drop;

    // rx_prev only goes high from genuinely sampled line data, so a frame cut by
    // reset cannot fake a falling edge once the reset-valued synchroniser drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b0;
            primed  <= '0;
        end else begin
            sync1   <= uart_rx;
            rx      <= sync1;
            primed  <= {primed[0], 1'b1};
            rx_prev <= rx & primed[1];
        end
    end

    assign bit_end = (tick == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (rx_prev && !rx) state_n = START;
            START:  if (tick == TICK_MID) state_n = rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_end && bit_cnt == 3'd7) state_n = PARITY;
            PARITY: if (bit_end) state_n = STOP;
`else
            DATA:   if (bit_end && bit_cnt == 3'd7) state_n = STOP;
`endif
            STOP:   if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        frame_ok = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample = 1'b0;
        par_set    = 1'b0;
        par_err    = ^{shift, par_bit};
`endif
        case (state)
            DATA: shift_en = bit_end;
`ifdef UART_RX_PARITY_EN
            PARITY: par_sample = bit_end;
            STOP: begin
                frame_ok = bit_end & rx & ~par_err;
                par_set  = bit_end & par_err;
            end
`else
            STOP: frame_ok = bit_end & rx;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            push_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (state_n != state || bit_end) tick <= '0;
            else                             tick <= tick + 1'b1;
            if (shift_en) begin
                shift   <= {rx, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (par_sample) par_bit <= rx;
`endif
            push_req <= frame_ok;
        end
    end

    // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
    assign pop  = re & ~empty;
    assign wr   = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        case ({wr, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
            dout    <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                dout <= mem[rp];
            end
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == FULL_CNT);
            if (drop)     overrun <= 1'b1;
            else if (pop) overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         perr <= 1'b0;
        else if (par_set) perr <= 1'b1;
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus hand-computed checks on the scenarios of interest.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BT    = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Line falls just after edge T0: 2 sync edges + 1 edge-detect edge, mid start bit
    // BT/2+1 edges later, then one sample per BT edges for every remaining bit.
    localparam int STOP_SAMPLE = 3 + BT / 2 + 1 + (NBITS - 1) * BT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       re = 1'b0;
    logic [7:0] dout;
    logic       empty, full, overrun, perr;

    uart_rx_fifo #(
        .CLK_FREQ(16),
        .BAUD_RATE(1),
        .FIFO_ADDR_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .re(re),
        .dout(dout),
        .empty(empty),
        .full(full),
        .overrun(overrun),
        .perr(perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         par_bad;
    } ev_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         model_on = 1'b0;
    logic [7:0] mq[$];
    ev_t        sched[$];
    logic       ov_m = 1'b0;
    logic       perr_m = 1'b0;
    logic [7:0] dout_m = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte queue updated once per clock edge.
    always @(posedge clk) begin
        bit  pop_m, drop_m;
        ev_t e;
        cyc = cyc + 1;
        if (rst) begin
            pop_m  = re && (mq.size() > 0);
            drop_m = 1'b0;
            if (pop_m) dout_m = mq.pop_front();
            while (sched.size() > 0 && sched[0].at == cyc) begin
                e = sched.pop_front();
                if (e.par_bad)              perr_m = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(e.data);
                else                        drop_m = 1'b1;
            end
            if (drop_m)     ov_m = 1'b1;
            else if (pop_m) ov_m = 1'b0;
        end
    end

    always @(negedge rst) begin
        mq.delete();
        sched.delete();
        ov_m     = 1'b0;
        perr_m   = 1'b0;
        dout_m   = 8'h00;
        model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("empty", empty, mq.size() == 0);
            check("full", full, mq.size() == DEPTH);
            check("overrun", overrun, ov_m);
            check("perr", perr, perr_m);
            check("dout", dout, dout_m);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting just after a posedge; schedules its expected outcome.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        ev_t e;
        bit  par_ok;
        int  t0;
        t0 = cyc;
`ifdef UART_RX_PARITY_EN
        par_ok = ((^d) ^ par_bit) == 1'b0;
`else
        par_ok = 1'b1;
`endif
        if (!par_ok) begin
            e.at = t0 + STOP_SAMPLE; e.data = d; e.par_bad = 1'b1;
            sched.push_back(e);
        end else if (stop_bit) begin
            e.at = t0 + STOP_SAMPLE + 1; e.data = d; e.par_bad = 1'b0;
            sched.push_back(e);
        end
        uart_rx = 1'b0;
        step(BT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            step(BT);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_bit;
        step(BT);
`endif
        uart_rx = stop_bit;
        step(BT);
        uart_rx = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        re = 1'b1;
        step(1);
        re = 1'b0;
        check(name, dout, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        int t0;
        #2 rst = 1'b0;
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_perr", perr, 1'b0);
        step(3);
        rst = 1'b1;
        step(4);

        // Single frame, exact push edge.
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                wait_edge(t0 + STOP_SAMPLE);
                check("a5_empty_at_stop", empty, 1'b1);
                wait_edge(t0 + STOP_SAMPLE + 1);
                check("a5_empty_after", empty, 1'b0);
            end
        join
        step(4);
        pop_check("a5_dout", 8'hA5);
        check("a5_empty_popped", empty, 1'b1);

        // Short low glitch while idle.
        uart_rx = 1'b0;
        step(4);
        uart_rx = 1'b1;
        step(40);
        check("glitch_empty", empty, 1'b1);

        // Fill past depth.
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b1, ^8'(v));
            step(4);
            if (v == 4) begin
                check("fill_full", full, 1'b1);
                check("fill_no_overrun", overrun, 1'b0);
            end
        end
        check("fill_overrun", overrun, 1'b1);
        pop_check("fill_pop1", 8'h01);
        check("fill_overrun_cleared", overrun, 1'b0);
        pop_check("fill_pop2", 8'h02);
        pop_check("fill_pop3", 8'h03);
        pop_check("fill_pop4", 8'h04);
        check("fill_empty", empty, 1'b1);

        // Push and pop on the same edge while full.
        for (int v = 1; v <= 4; v++) begin
            send_frame(8'(v), 1'b1, ^8'(v));
            step(4);
        end
        check("sim_full_before", full, 1'b1);
        t0 = cyc;
        fork
            send_frame(8'h06, 1'b1, ^8'h06);
            begin
                wait_edge(t0 + STOP_SAMPLE);
                re = 1'b1;
                step(1);
                re = 1'b0;
                check("sim_pop_dout", dout, 8'h01);
                check("sim_full_kept", full, 1'b1);
                check("sim_no_overrun", overrun, 1'b0);
            end
        join
        step(4);
        pop_check("sim_pop2", 8'h02);
        pop_check("sim_pop3", 8'h03);
        pop_check("sim_pop4", 8'h04);
        pop_check("sim_pop6", 8'h06);
        check("sim_empty", empty, 1'b1);

        // Framing error.
        send_frame(8'h3C, 1'b0, ^8'h3C);
        step(4);
        check("frame_err_empty", empty, 1'b1);
        check("frame_err_overrun", overrun, 1'b0);

        // Reset in the middle of a frame, with a byte already buffered.
        send_frame(8'h11, 1'b1, ^8'h11);
        step(4);
        check("pre_rst_empty", empty, 1'b0);
        t0 = cyc;
        fork
            send_frame(8'h55, 1'b1, ^8'h55);
            begin
                wait_edge(t0 + 60);
                rst = 1'b0;
                #1;
                check("midrst_dout", dout, 8'h00);
                check("midrst_empty", empty, 1'b1);
                check("midrst_full", full, 1'b0);
                check("midrst_overrun", overrun, 1'b0);
            end
        join
        step(3);
        rst = 1'b1;
        step(6);
        send_frame(8'h7E, 1'b1, ^8'h7E);
        step(4);
        check("post_rst_empty", empty, 1'b0);
        pop_check("post_rst_dout", 8'h7E);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        step(4);
        check("par_bad_perr", perr, 1'b1);
        check("par_bad_empty", empty, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        step(4);
        check("par_ok_empty", empty, 1'b0);
        pop_check("par_ok_dout", 8'h07);
        check("par_sticky", perr, 1'b1);
`else
        check("perr_tied", perr, 1'b0);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
